ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
// Translates raw PS/2 set-2 scancode bytes from the ps2 receiver into the key interface of the
// text-mode VGA terminal: press_flag, special_char, char_ascii.
// Tracks make/break, E0 prefixes, shift and caps lock.
// Sits between the PS/2 receiver FIFO and the VGA text display.
// PARAMETERS
// SPECIAL_W   4   width of special_char code
// PORTS
// clk             in   1  system clock (same clock as VGA display logic)
// clr             in   1  synchronous active-high reset
// ps2_data        in   8  scancode byte at receiver FIFO head
// ps2_ready       in   1  1 = FIFO non-empty, ps2_data valid
// ps2_overflow    in   1  receiver FIFO overflowed; byte stream lost sync
// ps2_nextdata_n  out  1  active-low pop strobe to receiver, exactly 1 cycle per consumed byte
// press_flag      out  1  1 while the last pressed non-modifier key is held
// special_char    out  4  0 none, 1 left, 2 up, 3 down, 4 right, 5 enter, 6 backspace
// char_ascii      out  8  ASCII of held printable key; 0 when special or none
// caps_led        out  1  caps-lock state
// BEHAVIOUR
// - Single clock, synchronous active-high reset. On clr: press_flag=0, special_char=0, char_ascii=0,
//   caps_led=0, ps2_nextdata_n=1, all prefix/modifier/held-key flags cleared, FSM->IDLE.
// - Byte FSM: IDLE -(ps2_ready)-> ACK -> DECODE -> IDLE.
//   ACK: latch ps2_data into code_r; drive ps2_nextdata_n=0.
//   ps2_nextdata_n is 1 in every other state.
//   3 cycles per byte; ps2_ready is sampled in IDLE only.
// - DECODE of code_r:
//   E0 -> ext=1
//   F0 -> brk=1
//   else -> process {ext,brk,code_r}, then clear ext and brk.
// - Shift (12, 59): make sets shift_l/shift_r; break clears it.
//   Shift never changes press_flag.
// - Caps (58): the first make while not caps_held toggles caps_led and sets caps_held.
//   Break clears caps_held. Typematic repeats do not re-toggle.
// - Special keys: E0 6B=1, E0 75=2, E0 72=3, E0 74=4, 5A or E0 5A=5, 66=6.
//   Make: special_char=code, char_ascii=0.
// - Printable keys are looked up in ps2_scan_rom; the ROM returns 0 for an unmapped key.
//   - Letters: uppercase iff (shift_l|shift_r)^caps_led.
//   - Digits and punctuation: shifted table iff shift is held; caps is ignored.
//   - Make: char_ascii=lookup, special_char=0.
//   - Unmapped make (ROM 0, not special, not modifier): ignored, outputs unchanged.
// - Accepted make: press_flag=1, held_code={ext,code} latched; the outputs update in the DECODE cycle
//   and register out on the next edge.
//   Typematic repeat of the same code: outputs are unchanged.
//   A different key while one is held: the last key wins, outputs are replaced.
// - Break matching held_code: press_flag=0, special_char=0, char_ascii=0.
//   Break of a non-held key: ignored.
// - Shift state is latched at make. A later shift change while a key is held does not alter char_ascii.
// - ps2_overflow=1 (any state):
//   - clear ext, brk, press_flag, special_char and char_ascii next cycle;
//   - return to IDLE; shift and caps are kept.
// - Outputs are levels and stay stable between decode events. The display samples them on its slow
//   refresh clock, so they are never pulses.
// STRUCTURE
// - Shared package ps2_defs: scancode constants (PREFIX_E0, PREFIX_F0, LSHIFT, RSHIFT, CAPS, ENTER,
//   BKSP, arrows); special_char codes (SP_NONE..SP_BKSP); FSM state encoding.
// - Sub-module ps2_scan_rom: combinational 256x8 lookup, inputs code[7:0] and shift.
//   Lowercase letters come from the unshifted table; case is resolved in the top module.
// - Top module: byte FSM, prefix flags, modifier regs, held-key compare, output regs.
// TESTING
// 1. Bytes 1C; F0 1C -> press_flag=1, char_ascii=8'h61 after the first byte; all outputs 0 after F0 1C.
// 2. Bytes 12 1C F0 1C F0 12 -> char_ascii=8'h41 while held; shift_l cleared at the end.
// 3. Bytes 58 F0 58 1C -> caps_led=1, char_ascii=8'h41.
//    Then F0 1C 12 1C -> char_ascii=8'h61.
//    Then 58 58 58 -> caps_led toggles once only.
// 4. Bytes E0 6B -> special_char=1, char_ascii=0, press_flag=1.
//    Then E0 F0 6B -> all 0.
//    Then 66 -> special_char=6; then 5A -> special_char=5 (last key wins).
// 5. Handshake: ps2_ready held 1 across 3 queued bytes -> exactly 3 single-cycle ps2_nextdata_n lows,
//    spaced 3 cycles apart.
// 6. clr pulsed after byte E0, then byte 6B -> E0 is forgotten, 6B is unmapped and ignored,
//    press_flag stays 0.
//    Separately: ps2_overflow during a held key -> outputs clear and caps_led is retained.

Source files
------------

// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 set-2 key decoder: scancodes, special-key codes,
// byte FSM encoding and the special-key classifier.
package ps2_defs;

    localparam logic [7:0] PREFIX_E0   = 8'hE0;
    localparam logic [7:0] PREFIX_F0   = 8'hF0;
    localparam logic [7:0] LSHIFT      = 8'h12;
    localparam logic [7:0] RSHIFT      = 8'h59;
    localparam logic [7:0] CAPS        = 8'h58;
    localparam logic [7:0] ENTER       = 8'h5A;
    localparam logic [7:0] BKSP        = 8'h66;
    localparam logic [7:0] ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] ARROW_UP    = 8'h75;
    localparam logic [7:0] ARROW_DOWN  = 8'h72;
    localparam logic [7:0] ARROW_RIGHT = 8'h74;

    localparam logic [3:0] SP_NONE  = 4'd0;
    localparam logic [3:0] SP_LEFT  = 4'd1;
    localparam logic [3:0] SP_UP    = 4'd2;
    localparam logic [3:0] SP_DOWN  = 4'd3;
    localparam logic [3:0] SP_RIGHT = 4'd4;
    localparam logic [3:0] SP_ENTER = 4'd5;
    localparam logic [3:0] SP_BKSP  = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    // Arrows exist only behind E0; Enter is accepted with or without the keypad prefix.
    function automatic logic [3:0] special_code(input logic ext, input logic [7:0] code);
        logic [3:0] sp;
        sp = SP_NONE;
        if (code == ENTER)
            sp = SP_ENTER;
        else if (!ext && code == BKSP)
            sp = SP_BKSP;
        else if (ext) begin
            case (code)
                ARROW_LEFT:  sp = SP_LEFT;
                ARROW_UP:    sp = SP_UP;
                ARROW_DOWN:  sp = SP_DOWN;
                ARROW_RIGHT: sp = SP_RIGHT;
                default:     sp = SP_NONE;
            endcase
        end
        return sp;
    endfunction

endpackage

// File: rtl/ps2_scan_rom.sv
// Set-2 scancode to ASCII lookup. Letters always come back lowercase; the caller
// resolves their case. Returns 0 for any code without a printable mapping.
module ps2_scan_rom
  import ps2_defs::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = "a";  8'h32: ascii = "b";  8'h21: ascii = "c";
      8'h23: ascii = "d";  8'h24: ascii = "e";  8'h2B: ascii = "f";
      8'h34: ascii = "g";  8'h33: ascii = "h";  8'h43: ascii = "i";
      8'h3B: ascii = "j";  8'h42: ascii = "k";  8'h4B: ascii = "l";
      8'h3A: ascii = "m";  8'h31: ascii = "n";  8'h44: ascii = "o";
      8'h4D: ascii = "p";  8'h15: ascii = "q";  8'h2D: ascii = "r";
      8'h1B: ascii = "s";  8'h2C: ascii = "t";  8'h3C: ascii = "u";
      8'h2A: ascii = "v";  8'h1D: ascii = "w";  8'h22: ascii = "x";
      8'h35: ascii = "y";  8'h1A: ascii = "z";  8'h29: ascii = " ";
      8'h45: ascii = shift ? ")" : "0";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h0E: ascii = shift ? "~" : 8'h60;
      8'h4E: ascii = shift ? "_" : "-";
      8'h55: ascii = shift ? "+" : "=";
      8'h54: ascii = shift ? "{" : "[";
      8'h5B: ascii = shift ? "}" : "]";
      8'h5D: ascii = shift ? "|" : 8'h5C;
      8'h4C: ascii = shift ? ":" : ";";
      8'h52: ascii = shift ? 8'h22 : "'";
      8'h41: ascii = shift ? "<" : ",";
      8'h49: ascii = shift ? ">" : ".";
      8'h4A: ascii = shift ? "?" : "/";
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to held-key levels for the VGA text terminal: make/break,
// E0 prefix, shift and caps-lock tracking, one 3-cycle pop/decode per byte.
module ps2_key_decoder
    import ps2_defs::*;
#(
    parameter int SPECIAL_W = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [7:0]           ps2_data,
    input  logic                 ps2_ready,
    input  logic                 ps2_overflow,
    output logic                 ps2_nextdata_n,
    output logic                 press_flag,
    output logic [SPECIAL_W-1:0] special_char,
    output logic [7:0]           char_ascii,
    output logic                 caps_led
);

    state_t                state, state_nxt;
    logic [7:0]            code_r;
    logic                  ext, brk, shift_l, shift_r, caps_held;
    logic [8:0]            held_code;

    logic                  ext_nxt, brk_nxt, shift_l_nxt, shift_r_nxt, caps_held_nxt;
    logic                  caps_led_nxt, press_nxt;
    logic [8:0]            held_nxt;
    logic [SPECIAL_W-1:0]  special_nxt;
    logic [7:0]            ascii_nxt;

    logic [8:0]            key;
    logic [3:0]            sp_code;
    logic [7:0]            rom_ascii, case_ascii;
    logic                  shift_any, is_letter;

    assign key       = {ext, code_r};
    assign shift_any = shift_l | shift_r;
    assign sp_code   = special_code(ext, code_r);
    assign is_letter = (rom_ascii >= 8'h61) && (rom_ascii <= 8'h7A);
    assign case_ascii = (is_letter && (shift_any ^ caps_led)) ? rom_ascii - 8'h20 : rom_ascii;

    ps2_scan_rom u_rom (
        .code  (code_r),
        .shift (shift_any),
        .ascii (rom_ascii)
    );

    // Pop strobe is low for exactly the one ACK cycle of each consumed byte.
    assign ps2_nextdata_n = (state != S_ACK);

    always_ff @(posedge clk) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (ps2_ready) state_nxt = S_ACK;
            S_ACK:    state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (ps2_overflow)
            state_nxt = S_IDLE;
    end

    always_comb begin
        ext_nxt       = ext;
        brk_nxt       = brk;
        shift_l_nxt   = shift_l;
        shift_r_nxt   = shift_r;
        caps_held_nxt = caps_held;
        caps_led_nxt  = caps_led;
        press_nxt     = press_flag;
        held_nxt      = held_code;
        special_nxt   = special_char;
        ascii_nxt     = char_ascii;

        if (state == S_DECODE) begin
            if (code_r == PREFIX_E0) begin
                ext_nxt = 1'b1;
            end else if (code_r == PREFIX_F0) begin
                brk_nxt = 1'b1;
            end else begin
                ext_nxt = 1'b0;
                brk_nxt = 1'b0;
                if (brk) begin
                    if (key == {1'b0, LSHIFT})
                        shift_l_nxt = 1'b0;
                    else if (key == {1'b0, RSHIFT})
                        shift_r_nxt = 1'b0;
                    else if (key == {1'b0, CAPS})
                        caps_held_nxt = 1'b0;
                    else if (press_flag && key == held_code) begin
                        press_nxt   = 1'b0;
                        special_nxt = '0;
                        ascii_nxt   = 8'h00;
                    end
                end else begin
                    if (key == {1'b0, LSHIFT})
                        shift_l_nxt = 1'b1;
                    else if (key == {1'b0, RSHIFT})
                        shift_r_nxt = 1'b1;
                    else if (key == {1'b0, CAPS}) begin
                        if (!caps_held) begin
                            caps_led_nxt  = ~caps_led;
                            caps_held_nxt = 1'b1;
                        end
                    end else if (press_flag && key == held_code) begin
                        // typematic repeat: keep the outputs latched at the original make
                    end else if (sp_code != SP_NONE) begin
                        press_nxt   = 1'b1;
                        held_nxt    = key;
                        special_nxt = SPECIAL_W'(sp_code);
                        ascii_nxt   = 8'h00;
                    end else if (!ext && rom_ascii != 8'h00) begin
                        press_nxt   = 1'b1;
                        held_nxt    = key;
                        special_nxt = '0;
                        ascii_nxt   = case_ascii;
                    end
                end
            end
        end

        if (ps2_overflow) begin
            ext_nxt     = 1'b0;
            brk_nxt     = 1'b0;
            press_nxt   = 1'b0;
            special_nxt = '0;
            ascii_nxt   = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            code_r       <= 8'h00;
            ext          <= 1'b0;
            brk          <= 1'b0;
            shift_l      <= 1'b0;
            shift_r      <= 1'b0;
            caps_held    <= 1'b0;
            caps_led     <= 1'b0;
            press_flag   <= 1'b0;
            held_code    <= 9'h000;
            special_char <= '0;
            char_ascii   <= 8'h00;
        end else begin
            if (state == S_ACK)
                code_r <= ps2_data;
            ext          <= ext_nxt;
            brk          <= brk_nxt;
            shift_l      <= shift_l_nxt;
            shift_r      <= shift_r_nxt;
            caps_held    <= caps_held_nxt;
            caps_led     <= caps_led_nxt;
            press_flag   <= press_nxt;
            held_code    <= held_nxt;
            special_char <= special_nxt;
            char_ascii   <= ascii_nxt;
        end
    end

endmodule
